core_6502: RTL and testbench
============================

# core_6502

Reduced NMOS-6502-compatible CPU core for the single-RAM simulation top level. It boots from the reset vector at $FFFC/$FFFD and executes a defined opcode subset with 6502 cycle counts. It talks to a synchronous RAM with one cycle of read latency. Any opcode outside the subset halts the core and raises `jam`.

## Interface
- No parameters.
- `i_clk` in 1: clock; all state changes on the rising edge.
- `i_rst` in 1: asynchronous, active-low reset.
- `i_data` in 8: read data for the address driven in the previous cycle.
- `READY` in 1: 1 = run, 0 = stall.
- `SV` in 1: set-overflow input.
- `NMI` in 1: reserved, ignored.
- `IRQ` in 1: reserved, ignored.
- `addr` out 16: bus address, valid every cycle.
- `dor` out 8: write data, valid when `RW`=0.
- `RW` out 1: 1 = read, 0 = write (RAM writes `dor` at the end of the cycle).
- `sync` out 1: high during opcode-fetch cycles.
- `jam` out 1: high once an undefined opcode has been fetched.

## Operation
- Registers: A, X, Y, S, PC (16 bit), P = N V 1 B D I Z C.
- Reset values: A=X=Y=0, S=$FD, P=$34, PC=0.
- Output values during reset: `addr`=$FFFC, `RW`=1, `dor`=0, `sync`=0, `jam`=0.
- Supported opcodes use standard 6502 encodings:
  - LDA/LDX/LDY: #imm, zp, abs.
  - STA/STX/STY: zp, abs.
  - ADC/SBC/AND/ORA/EOR/CMP: #imm, zp, abs.
  - Implied: INX INY DEX DEY TAX TXA TAY TYA CLC SEC CLV NOP.
  - JMP abs.
  - BPL BMI BVC BVS BCC BCS BNE BEQ.
- Flags:
  - N and Z are set from the result on loads, transfers, INC/DEC, AND/ORA/EOR, ADC/SBC and CMP.
  - ADC/SBC are always binary and also update C and V; SBC computes A + ~M + C.
  - CMP sets C = (A ≥ M) and does not change A.
  - The D flag is stored but ignored.
- Branches: offset is signed 8-bit, relative to the address of the next instruction; PC arithmetic wraps modulo 2^16.
- Undefined opcode: `jam`=1, `sync`=0, `RW`=1, `addr` frozen, all state frozen until reset.
- `SV`=1 at a rising edge sets V. This has priority over any V update in the same cycle.
- `READY`=0 freezes all state and bus outputs.
  - On the first stalled cycle, `i_data` is captured.
  - When `READY` returns to 1, the captured byte is used as the previous cycle's read data.

## Timing
- Bus protocol:
  - `addr`, `RW` and `dor` are driven combinationally from state and may depend on `i_data`.
  - Read data for cycle n appears on `i_data` in cycle n+1.
- Boot sequence after reset release, one bus access per cycle:
  - C0: `addr`=$FFFC.
  - C1: `addr`=$FFFD; the low vector byte on `i_data` is latched.
  - C2: `addr` held at $FFFD; the high vector byte is latched.
  - C3: first opcode fetch, `addr`=vector, `sync`=1.
- Per-instruction bus cycles (T0 = opcode fetch, `addr`=PC, `sync`=1):
  - T1: `addr`=PC+1.
  - zp mode: T2 `addr`={$00, `i_data`}.
  - abs mode: T2 `addr`=PC+2 (low byte latched); T3 `addr`={`i_data`, low}.
- Cycle counts:
  - implied/#imm: 2.
  - zp read or write: 3.
  - abs read or write: 4.
  - JMP abs: 3.
  - branch not taken: 2; taken: 3, with no page-cross penalty.
- Stores drive `RW`=0 and `dor`=source register in their final cycle only.
- Read-type results are written to registers/P at the end of the following T0 (pipelined overlap, as on the 6502).
- Implied-op results are visible by the following T0.
- Reset asserted mid-instruction aborts it immediately, with no partial write.

## Test plan
- Boot: vector $00A0 at $FFFC/$FFFD, release reset → `addr` is $FFFC, $FFFD, $FFFD, then $00A0 with `sync`=1 on the 4th cycle.
- Load/store: A9 42 8D 00 02 at $00A0 → RAM[$0200]=$42 written in cycle 6 after the first sync, with `RW`=0 and `dor`=$42; Z=0, N=0.
- ADC: CLC; LDA #$7F; ADC #$01 → A=$80, N=1, V=1, C=0, Z=0.
- SBC/CMP: SEC; LDA #$10; SBC #$10 → A=0, Z=1, C=1; then CMP #$01 → C=0, N=1.
- Loop: LDX #$03; DEX; BNE -3 → BNE taken twice (3 cycles each), then not taken (2 cycles); X=0, Z=1.
- Jam and stall:
  - Opcode $02 → `jam`=1 on the next cycle and bus frozen until reset.
  - `READY`=0 for 5 cycles mid-LDA abs → same result with timing extended by 5 cycles.
  - `SV` pulse → V=1.

Source files
------------

// File: rtl/core_6502.sv
// core_6502: reduced NMOS-6502-compatible core. Boots from $FFFC/$FFFD,
// runs a load/store/ALU/implied/JMP/branch subset with 6502 cycle counts
// against a synchronous RAM with one cycle of read latency.
module core_6502 (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_data,
  input  logic        READY,
  input  logic        SV,
  input  logic        NMI,
  input  logic        IRQ,
  output logic [15:0] addr,
  output logic [7:0]  dor,
  output logic        RW,
  output logic        sync,
  output logic        jam
);

  typedef enum logic [2:0] {S_BOOT0, S_BOOT1, S_BOOT2, S_T0, S_T1, S_T2, S_T3, S_JAM} state_t;
  typedef enum logic [2:0] {K_BAD, K_IMP, K_READ, K_STORE, K_JMP, K_BR} kind_t;
  typedef enum logic [1:0] {M_IMM, M_ZP, M_ABS} mode_t;
  typedef enum logic [3:0] {U_LDA, U_LDX, U_LDY, U_ADC, U_SBC, U_AND, U_ORA, U_EOR, U_CMP} alu_t;
  typedef enum logic [1:0] {R_A, R_X, R_Y, R_NONE} reg_t;
  typedef struct packed {
    kind_t kind;
    mode_t mode;
    alu_t  alu;
    reg_t  src;
  } dec_t;

  function automatic dec_t decode(input logic [7:0] op);
    dec_t d;
    d.kind = K_BAD;
    d.alu  = U_LDA;
    d.src  = R_A;
    d.mode = (op[3:2] == 2'b01) ? M_ZP : (op[3:2] == 2'b11) ? M_ABS : M_IMM;
    case (op)
      8'hA9, 8'hA5, 8'hAD: begin d.kind = K_READ; d.alu = U_LDA; end
      8'hA2, 8'hA6, 8'hAE: begin d.kind = K_READ; d.alu = U_LDX; end
      8'hA0, 8'hA4, 8'hAC: begin d.kind = K_READ; d.alu = U_LDY; end
      8'h69, 8'h65, 8'h6D: begin d.kind = K_READ; d.alu = U_ADC; end
      8'hE9, 8'hE5, 8'hED: begin d.kind = K_READ; d.alu = U_SBC; end
      8'h29, 8'h25, 8'h2D: begin d.kind = K_READ; d.alu = U_AND; end
      8'h09, 8'h05, 8'h0D: begin d.kind = K_READ; d.alu = U_ORA; end
      8'h49, 8'h45, 8'h4D: begin d.kind = K_READ; d.alu = U_EOR; end
      8'hC9, 8'hC5, 8'hCD: begin d.kind = K_READ; d.alu = U_CMP; end
      8'h85, 8'h8D:        begin d.kind = K_STORE; d.src = R_A; end
      8'h86, 8'h8E:        begin d.kind = K_STORE; d.src = R_X; end
      8'h84, 8'h8C:        begin d.kind = K_STORE; d.src = R_Y; end
      8'h4C:               d.kind = K_JMP;
      8'hE8, 8'hC8, 8'hCA, 8'h88, 8'hAA, 8'h8A, 8'hA8, 8'h98,
      8'h18, 8'h38, 8'hB8, 8'hEA: d.kind = K_IMP;
      8'h10, 8'h30, 8'h50, 8'h70, 8'h90, 8'hB0, 8'hD0, 8'hF0: d.kind = K_BR;
      default: ;
    endcase
    return d;
  endfunction

  state_t      state;
  logic [7:0]  a, x, y, s, p, ir, lo, hold;
  logic [15:0] pc;
  logic        wb_pend, jmp_pend, rdy_q;
  alu_t        wb_op;

  logic [7:0]  din;
  dec_t        dn, di;
  logic [7:0]  st_val;
  logic [7:0]  opnd, wb_val, imp_val;
  logic [8:0]  sum;
  logic        ovf, wb_c, wb_v, br_flag, br_take;
  reg_t        wb_dst, imp_dst;
  logic        unused_bits;

  assign unused_bits = ^{NMI, IRQ, s, p[5:2], dn, di};

  // After a stall the byte captured on its first cycle stands in for i_data
  assign din = rdy_q ? i_data : hold;

  // Decode the opcode arriving now (T1) and the latched one (T2/T3)
  always_comb begin
    dn = decode(din);
    di = decode(ir);
  end

  // Store source register and branch condition
  always_comb begin
    case (di.src)
      R_X:     st_val = x;
      R_Y:     st_val = y;
      default: st_val = a;
    endcase
    case (din[7:6])
      2'b00:   br_flag = p[7];
      2'b01:   br_flag = p[6];
      2'b10:   br_flag = p[0];
      default: br_flag = p[1];
    endcase
    br_take = (br_flag == din[5]);
  end

  // Pipelined ALU: operand arrives during the next T0
  always_comb begin
    opnd   = (wb_op == U_SBC || wb_op == U_CMP) ? ~din : din;
    sum    = {1'b0, a} + {1'b0, opnd} + {8'h00, (wb_op == U_CMP) ? 1'b1 : p[0]};
    ovf    = (a[7] == opnd[7]) && (sum[7] != a[7]);
    wb_val = din;
    wb_dst = R_A;
    wb_c   = 1'b0;
    wb_v   = 1'b0;
    case (wb_op)
      U_LDX:        wb_dst = R_X;
      U_LDY:        wb_dst = R_Y;
      U_ADC, U_SBC: begin wb_val = sum[7:0]; wb_c = 1'b1; wb_v = 1'b1; end
      U_AND:        wb_val = a & din;
      U_ORA:        wb_val = a | din;
      U_EOR:        wb_val = a ^ din;
      U_CMP:        begin wb_val = sum[7:0]; wb_dst = R_NONE; wb_c = 1'b1; end
      default: ;
    endcase
  end

  // Implied-op result, completed at the end of T1
  always_comb begin
    imp_val = a;
    imp_dst = R_NONE;
    case (din)
      8'hE8: begin imp_val = x + 8'd1; imp_dst = R_X; end
      8'hC8: begin imp_val = y + 8'd1; imp_dst = R_Y; end
      8'hCA: begin imp_val = x - 8'd1; imp_dst = R_X; end
      8'h88: begin imp_val = y - 8'd1; imp_dst = R_Y; end
      8'hAA: begin imp_val = a;        imp_dst = R_X; end
      8'h8A: begin imp_val = x;        imp_dst = R_A; end
      8'hA8: begin imp_val = a;        imp_dst = R_Y; end
      8'h98: begin imp_val = y;        imp_dst = R_A; end
      default: ;
    endcase
  end

  // Bus outputs; T0 after JMP and the zp/abs data cycles use din directly
  always_comb begin
    addr = pc;
    RW   = 1'b1;
    dor  = '0;
    sync = 1'b0;
    jam  = 1'b0;
    case (state)
      S_BOOT0: addr = 16'hFFFC;
      S_BOOT1,
      S_BOOT2: addr = 16'hFFFD;
      S_T0: begin
        sync = 1'b1;
        addr = jmp_pend ? {din, lo} : pc;
      end
      S_T1: jam = (dn.kind == K_BAD);
      S_T2: begin
        if ((di.kind == K_READ || di.kind == K_STORE) && di.mode == M_ZP) begin
          addr = {8'h00, din};
          if (di.kind == K_STORE) begin
            RW  = 1'b0;
            dor = st_val;
          end
        end
      end
      S_T3: begin
        addr = {din, lo};
        if (di.kind == K_STORE) begin
          RW  = 1'b0;
          dor = st_val;
        end
      end
      S_JAM: jam = 1'b1;
      default: ;
    endcase
  end

  // Sequencer, register file and flags
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state    <= S_BOOT0;
      a        <= '0;
      x        <= '0;
      y        <= '0;
      s        <= 8'hFD;
      p        <= 8'h34;
      pc       <= '0;
      ir       <= '0;
      lo       <= '0;
      hold     <= '0;
      wb_pend  <= 1'b0;
      jmp_pend <= 1'b0;
      wb_op    <= U_LDA;
      rdy_q    <= 1'b1;
    end else if (state != S_JAM) begin
      rdy_q <= READY;
      if (!READY && rdy_q) hold <= i_data;
      if (READY) begin
        case (state)
          S_BOOT0: state <= S_BOOT1;
          S_BOOT1: begin
            lo    <= din;
            state <= S_BOOT2;
          end
          S_BOOT2: begin
            pc    <= {din, lo};
            state <= S_T0;
          end
          S_T0: begin
            pc       <= jmp_pend ? ({din, lo} + 16'd1) : (pc + 16'd1);
            jmp_pend <= 1'b0;
            wb_pend  <= 1'b0;
            if (wb_pend) begin
              case (wb_dst)
                R_A:     a <= wb_val;
                R_X:     x <= wb_val;
                R_Y:     y <= wb_val;
                default: ;
              endcase
              p[7] <= wb_val[7];
              p[1] <= (wb_val == 8'h00);
              if (wb_c) p[0] <= sum[8];
              if (wb_v) p[6] <= ovf;
            end
            state <= S_T1;
          end
          S_T1: begin
            ir <= din;
            case (dn.kind)
              K_IMP: begin
                case (imp_dst)
                  R_A:     a <= imp_val;
                  R_X:     x <= imp_val;
                  R_Y:     y <= imp_val;
                  default: ;
                endcase
                if (imp_dst != R_NONE) begin
                  p[7] <= imp_val[7];
                  p[1] <= (imp_val == 8'h00);
                end
                if (din == 8'h18) p[0] <= 1'b0;
                if (din == 8'h38) p[0] <= 1'b1;
                if (din == 8'hB8) p[6] <= 1'b0;
                state <= S_T0;
              end
              K_READ: begin
                pc <= pc + 16'd1;
                if (dn.mode == M_IMM) begin
                  wb_pend <= 1'b1;
                  wb_op   <= dn.alu;
                  state   <= S_T0;
                end else begin
                  state <= S_T2;
                end
              end
              K_STORE, K_JMP: begin
                pc    <= pc + 16'd1;
                state <= S_T2;
              end
              K_BR: begin
                pc    <= pc + 16'd1;
                state <= br_take ? S_T2 : S_T0;
              end
              default: state <= S_JAM;
            endcase
          end
          S_T2: begin
            case (di.kind)
              K_BR: begin
                pc    <= pc + {{8{din[7]}}, din};
                state <= S_T0;
              end
              K_JMP: begin
                lo       <= din;
                jmp_pend <= 1'b1;
                state    <= S_T0;
              end
              default: begin
                if (di.mode == M_ZP) begin
                  if (di.kind == K_READ) begin
                    wb_pend <= 1'b1;
                    wb_op   <= di.alu;
                  end
                  state <= S_T0;
                end else begin
                  lo    <= din;
                  pc    <= pc + 16'd1;
                  state <= S_T3;
                end
              end
            endcase
          end
          S_T3: begin
            if (di.kind == K_READ) begin
              wb_pend <= 1'b1;
              wb_op   <= di.alu;
            end
            state <= S_T0;
          end
          default: ;
        endcase
        // Placed last so SV wins over any V update in the same cycle
        if (SV) p[6] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_core_6502.sv
// Testbench for core_6502: synchronous RAM model plus a write scoreboard.
module tb_core_6502;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ready = 1'b1;
  logic        sv = 1'b0;
  logic [7:0]  rdata = '0;
  logic [15:0] addr;
  logic [7:0]  dor;
  logic        rw, sync, jam;

  logic [7:0]  mem [0:65535];
  int unsigned cyc = 0;
  int unsigned c0 = 0;
  int unsigned wcount = 0;
  int unsigned n_tests = 0;
  int unsigned n_fail = 0;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
    int unsigned r;
  } wexp_t;
  wexp_t wq[$];

  core_6502 dut (
    .i_clk (clk),
    .i_rst (rst_n),
    .i_data(rdata),
    .READY (ready),
    .SV    (sv),
    .NMI   (1'b0),
    .IRQ   (1'b0),
    .addr  (addr),
    .dor   (dor),
    .RW    (rw),
    .sync  (sync),
    .jam   (jam)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rdata <= mem[addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc - c0);
    end
  endtask

  task automatic monitor();
    wexp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && ready && !rw) begin
        wcount++;
        check("wr_expected", 32'(wq.size() != 0), 32'd1);
        if (wq.size() != 0) begin
          e = wq.pop_front();
          check("wr_addr", 32'(addr), 32'(e.a));
          check("wr_data", 32'(dor), 32'(e.d));
          check("wr_cycle", cyc - c0, e.r);
        end
      end
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'hFFFC] = 8'hA0;
    mem[16'hFFFD] = 8'h00;
  endtask

  task automatic load(input logic [15:0] base, input int unsigned n, input logic [127:0] bytes);
    for (int unsigned i = 0; i < n; i++) mem[base + 16'(i)] = bytes[8*(n-1-i) +: 8];
  endtask

  task automatic expect_wr(input logic [15:0] a, input logic [7:0] d, input int unsigned r);
    wexp_t e;
    e.a = a;
    e.d = d;
    e.r = r;
    wq.push_back(e);
  endtask

  task automatic hold_reset();
    rst_n = 1'b0;
    ready = 1'b1;
    sv    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    c0     = cyc;
    wcount = 0;
  endtask

  task automatic goto_cycle(input int unsigned r);
    while (cyc - c0 < r) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_writes(input int unsigned n);
    for (int i = 0; i < 300 && wcount < n; i++) @(posedge clk);
    #1;
    check("wr_seen", wcount, n);
  endtask

  logic [15:0] boot_exp [4];

  initial begin
    boot_exp = '{16'hFFFC, 16'hFFFD, 16'hFFFD, 16'h00A0};
    fork
      monitor();
    join_none

    // Reset state and boot sequence
    clear_mem();
    load(16'h00A0, 3, 128'h4C_A0_00);
    hold_reset();
    @(negedge clk);
    check("rst_addr", 32'(addr), 32'hFFFC);
    check("rst_rw", 32'(rw), 32'd1);
    check("rst_dor", 32'(dor), 32'd0);
    check("rst_sync", 32'(sync), 32'd0);
    check("rst_jam", 32'(jam), 32'd0);
    check("rst_regs", {dut.a, dut.x, dut.y, dut.s}, 32'h000000FD);
    check("rst_p", 32'(dut.p), 32'h34);
    check("rst_pc", 32'(dut.pc), 32'h0);
    release_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("boot_addr", 32'(addr), 32'(boot_exp[i]));
      check("boot_sync", 32'(sync), 32'(i == 3));
    end

    // LDA #$42; STA $0200
    hold_reset();
    clear_mem();
    load(16'h00A0, 8, 128'hA9_42_8D_00_02_4C_A5_00);
    expect_wr(16'h0200, 8'h42, 8);
    release_reset();
    wait_writes(1);
    check("ld_nz", {dut.p[7], dut.p[1]}, 32'd0);

    // JMP $0500; CLC; LDA #$7F; ADC #$01; STA $10
    hold_reset();
    clear_mem();
    load(16'h00A0, 3, 128'h4C_00_05);
    load(16'h0500, 10, 128'h18_A9_7F_69_01_85_10_4C_07_05);
    expect_wr(16'h0010, 8'h80, 14);
    release_reset();
    wait_writes(1);
    check("adc_nvzc", {dut.p[7], dut.p[6], dut.p[1], dut.p[0]}, 32'b1100);

    // SEC; LDA #$10; SBC #$10; STA $20; CMP #$01; STA $21
    hold_reset();
    clear_mem();
    load(16'h00A0, 14, 128'h38_A9_10_E9_10_85_20_C9_01_85_21_4C_AB_00);
    expect_wr(16'h0020, 8'h00, 11);
    expect_wr(16'h0021, 8'h00, 16);
    release_reset();
    wait_writes(1);
    check("sbc_zc", {dut.p[1], dut.p[0]}, 32'b11);
    wait_writes(2);
    check("cmp_nc", {dut.p[7], dut.p[0]}, 32'b10);

    // LDX #3; DEX; BNE -3; STX $30, then SV pulse while idling
    hold_reset();
    clear_mem();
    load(16'h00A0, 10, 128'hA2_03_CA_D0_FD_86_30_4C_A7_00);
    expect_wr(16'h0030, 8'h00, 21);
    release_reset();
    wait_writes(1);
    check("loop_z", 32'(dut.p[1]), 32'd1);
    check("sv_before", 32'(dut.p[6]), 32'd0);
    sv = 1'b1;
    @(posedge clk);
    #1;
    sv = 1'b0;
    check("sv_after", 32'(dut.p[6]), 32'd1);

    // LDA $1234; STA $0300 without and with a 5-cycle stall in the LDA
    for (int stall = 0; stall < 2; stall++) begin
      hold_reset();
      clear_mem();
      load(16'h00A0, 9, 128'hAD_34_12_8D_00_03_4C_A6_00);
      mem[16'h1234] = 8'h5A;
      expect_wr(16'h0300, 8'h5A, (stall != 0) ? 15 : 10);
      release_reset();
      if (stall != 0) begin
        goto_cycle(5);
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          check("stall_addr", 32'(addr), 32'h00A2);
        end
        goto_cycle(10);
        ready = 1'b1;
      end
      wait_writes(1);
    end

    // LDA #1; opcode $02 jams with a frozen bus
    hold_reset();
    clear_mem();
    load(16'h00A0, 3, 128'hA9_01_02);
    release_reset();
    goto_cycle(5);
    @(negedge clk);
    check("jam_pre", {15'd0, jam, addr}, {15'd0, 1'b0, 16'h00A2});
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("jam_bus", {13'd0, jam, sync, rw, addr}, {13'd0, 1'b1, 1'b0, 1'b1, 16'h00A3});
    end
    hold_reset();
    check("jam_clear", 32'(jam), 32'd0);

    // Reset during STA abs aborts it, then a clean rerun writes
    clear_mem();
    load(16'h00A0, 8, 128'hA9_42_8D_00_02_4C_A5_00);
    release_reset();
    goto_cycle(7);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_rw", 32'(rw), 32'd1);
    repeat (3) @(posedge clk);
    expect_wr(16'h0200, 8'h42, 8);
    release_reset();
    wait_writes(1);

    repeat (4) @(posedge clk);
    check("wq_empty", 32'(wq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
